keypad_scanner: RTL and testbench

//  Scans a 4x4 hex keypad (Pmod KYPD) by driving one column low at a time and

---
 rtl/keypad_scanner.sv | 134 +++++++++++++
 tb/tb_keypad_scanner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x4 hex keypad with whole-frame debounce and a 4-digit code history.
module keypad_scanner #(
    parameter int DWELL_CYCLES    = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] digits
);
    localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_FRAMES);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;
    // nibble (row*4 + col) holds the legend of that key
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    acc_q, acc_d;
    logic [3:0]    last_q, last_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;
    logic [15:0]   digits_q, digits_d;

    logic          dwell_end, frame_end;
    logic [3:0]    pressed;
    logic [2:0]    hits, sum;
    logic [1:0]    hit_row, frame_n;
    logic [3:0]    col_key, frame_key;
    logic [CW-1:0] cnt_next, rel_next;

    assign dwell_end = dwell_q == DWELL_LAST;
    assign frame_end = dwell_end && col_idx_q == 2'd3;
    assign pressed   = ~row_sync_q;
    assign hits      = {2'b0, pressed[0]} + {2'b0, pressed[1]} + {2'b0, pressed[2]} + {2'b0, pressed[3]};
    assign hit_row   = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
    assign col_key   = KEY_MAP[{hit_row, col_idx_q, 2'b00} +: 4];
    assign sum       = {1'b0, acc_q} + hits;
    // the running key count only needs to distinguish 0, 1 and "2 or more"
    assign frame_n   = sum >= 3'd2 ? 2'd2 : sum[1:0];
    assign frame_key = hits == 3'd1 ? col_key : last_q;
    assign cnt_next  = frame_key != cand_q ? CW'(1) : cnt_q == DB_MAX ? cnt_q : cnt_q + CW'(1);
    assign rel_next  = rel_q == DB_MAX ? rel_q : rel_q + CW'(1);

    always_comb begin
        dwell_d     = dwell_end ? '0 : dwell_q + DW'(1);
        col_idx_d   = dwell_end ? col_idx_q + 2'd1 : col_idx_q;
        acc_d       = dwell_end ? (frame_end ? 2'd0 : frame_n) : acc_q;
        last_d      = dwell_end ? (frame_end ? 4'd0 : frame_key) : last_q;
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        digits_d    = digits_q;
        if (frame_end && state_q == IDLE) begin
            cand_d = frame_n == 2'd1 ? frame_key : cand_q;
            cnt_d  = frame_n == 2'd1 ? cnt_next : '0;
            if (frame_n == 2'd1 && cnt_next == DB_MAX) begin
                state_d     = HELD;
                cnt_d       = '0;
                rel_d       = '0;
                key_code_d  = frame_key;
                key_valid_d = 1'b1;
                key_down_d  = 1'b1;
                digits_d    = {digits_q[11:0], frame_key};
            end
        end
        if (frame_end && state_q == HELD) begin
            rel_d = frame_n == 2'd0 ? rel_next : '0;
            if (frame_n == 2'd0 && rel_next == DB_MAX) begin
                state_d    = IDLE;
                cnt_d      = '0;
                rel_d      = '0;
                key_down_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            acc_q       <= 2'd0;
            last_q      <= 4'd0;
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            rel_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            digits_q    <= 16'd0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            acc_q       <= acc_d;
            last_q      <= last_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            digits_q    <= digits_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign digits    = digits_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving keypad_scanner; accepted codes are checked against a queue of expected presses.
module tb_keypad_scanner;
    localparam int DWELL = 8;
    localparam int DEB   = 2;
    localparam int FRAME = 4 * DWELL;
    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, KA = 16'h0008, K4 = 16'h0010;
    localparam logic [15:0] K5 = 16'h0020, K6 = 16'h0040, K7 = 16'h0100, K9 = 16'h0400;
    localparam logic [15:0] K0 = 16'h1000, KD = 16'h8000;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] dig;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] digits;
    logic [15:0] keys = 16'h0;
    logic [15:0] exp_digits = 16'h0;
    logic [3:0]  exp_col;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    keypad_scanner #(.DWELL_CYCLES(DWELL), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .digits(digits)
    );

    always #5 clk = ~clk;

    // a held key shorts its row to its column, so a row reads low while any pressed key's column is driven low
    always_comb
        for (int r = 0; r < 4; r++)
            row[r] = ~|(keys[r*4 +: 4] & ~col);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clk);
        #1;
    endtask

    task automatic expect_key(input logic [3:0] k);
        exp_digits = {exp_digits[11:0], k};
        sb.push_back('{k, exp_digits});
    endtask

    task automatic check_reset_values();
        check("rst_col", 32'(col), 32'hE);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_down", 32'(key_down), 32'h0);
        check("rst_digits", 32'(digits), 32'h0);
    endtask

    task automatic tap(input logic [15:0] k, input logic [3:0] code);
        expect_key(code);
        keys = k;
        frames(3);
        keys = 16'h0;
        frames(2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && key_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(key_code), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("pulse_code", 32'(key_code), 32'(e.code));
                    check("pulse_digits", 32'(digits), 32'(e.dig));
                    check("pulse_key_down", 32'(key_down), 32'h1);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            exp_col = ~(4'b0001 << ((n / DWELL) % 4));
            check("col_scan", 32'(col), 32'(exp_col));
            @(negedge clk);
        end
        #1;
        check("idle_digits", 32'(digits), 32'h0);

        expect_key(4'h5);
        keys = K5;
        frames(12);
        check("t2_one_pulse", sb.size(), 0);
        check("t2_held", 32'(key_down), 32'h1);
        keys = 16'h0;
        frames(1);
        check("t2_held_1_empty", 32'(key_down), 32'h1);
        frames(1);
        check("t2_released", 32'(key_down), 32'h0);
        check("t2_digits", 32'(digits), 32'h0005);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_digits = 16'h0;
        tap(KA, 4'hA);
        tap(K0, 4'h0);
        check("t3_pulses", sb.size(), 0);
        check("t3_digits", 32'(digits), 32'h00A0);

        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? K7 : 16'h0;
            frames(1);
        end
        expect_key(4'h6);
        keys = K4;
        frames(1);
        keys = K6;
        frames(2);
        check("t4_pulse", sb.size(), 0);
        check("t4_code", 32'(key_code), 32'h6);
        keys = 16'h0;
        frames(2);

        keys = K1 | K2;
        frames(6);
        check("t5_multi_no_accept", 32'(key_down), 32'h0);
        expect_key(4'h2);
        keys = K2;
        frames(2);
        check("t5_pulse", sb.size(), 0);
        check("t5_held", 32'(key_down), 32'h1);
        keys = K2 | KD;
        frames(4);
        check("t5_still_held", 32'(key_down), 32'h1);
        keys = 16'h0;
        frames(2);
        check("t5_released", 32'(key_down), 32'h0);
        check("t5_digits", 32'(digits), 32'hA062);

        keys = K9;
        frames(1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        exp_digits = 16'h0;
        expect_key(4'h9);
        frames(1);
        check("t6_no_early_pulse", sb.size(), 1);
        frames(1);
        check("t6_pulse", sb.size(), 0);
        check("t6_code", 32'(key_code), 32'h9);
        keys = 16'h0;
        frames(2);
        check("t6_released", 32'(key_down), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
